vend_purchase_ctrl: RTL and testbench

VEND_PURCHASE_CTRL -- requirements
Module: vend_purchase_ctrl

---
 rtl/vend_purchase_ctrl_pkg.sv | 49 ++++
 rtl/vend_purchase_ctrl_if.sv | 28 ++
 rtl/vend_purchase_ctrl_stock_bank.sv | 34 +++
 rtl/vend_purchase_ctrl.sv | 138 +++++++++++++
 tb/tb_vend_purchase_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/vend_purchase_ctrl_pkg.sv
// Shared types, prices and coin rules for the vending purchase controller.
package vend_purchase_ctrl_pkg;

  localparam int unsigned NUM_GOODS = 7;
  localparam int unsigned STOCK_W   = 3;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned COIN_W    = 3;
  localparam int unsigned AMT_W     = 5;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned FLAT_W    = NUM_GOODS * STOCK_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PAY      = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_e;

  localparam logic [STOCK_W-1:0] STOCK_MAX = 3'd7;

  localparam logic [AMT_W-1:0] PRICE1 = 5'd2;
  localparam logic [AMT_W-1:0] PRICE2 = 5'd3;
  localparam logic [AMT_W-1:0] PRICE3 = 5'd3;
  localparam logic [AMT_W-1:0] PRICE4 = 5'd4;
  localparam logic [AMT_W-1:0] PRICE5 = 5'd5;
  localparam logic [AMT_W-1:0] PRICE6 = 5'd5;
  localparam logic [AMT_W-1:0] PRICE7 = 5'd7;

  localparam logic [COIN_W-1:0] COIN_1 = 3'd1;
  localparam logic [COIN_W-1:0] COIN_2 = 3'd2;
  localparam logic [COIN_W-1:0] COIN_5 = 3'd5;

  function automatic logic [AMT_W-1:0] price_of(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    return PRICE1;
      3'd1:    return PRICE2;
      3'd2:    return PRICE3;
      3'd3:    return PRICE4;
      3'd4:    return PRICE5;
      3'd5:    return PRICE6;
      default: return PRICE7;
    endcase
  endfunction

  function automatic logic coin_legal(input logic [COIN_W-1:0] v);
    return (v == COIN_1) || (v == COIN_2) || (v == COIN_5);
  endfunction

endpackage

// File: rtl/vend_purchase_ctrl_if.sv
// Customer-side command and status bundle of the purchase controller.
interface vend_purchase_ctrl_if;
  import vend_purchase_ctrl_pkg::*;

  logic              sel_next;
  logic              confirm;
  logic              cancel;
  logic              coin_valid;
  logic [COIN_W-1:0] coin_val;
  logic              restock;
  logic [IDX_W-1:0]  behavior;
  logic [FLAT_W-1:0] goodleft;
  logic [1:0]        state;
  logic [AMT_W-1:0]  paid;
  logic [AMT_W-1:0]  change;
  logic              dispense;
  logic              sold_out;

  modport master (
    output sel_next, confirm, cancel, coin_valid, coin_val, restock,
    input  behavior, goodleft, state, paid, change, dispense, sold_out
  );

  modport slave (
    input  sel_next, confirm, cancel, coin_valid, coin_val, restock,
    output behavior, goodleft, state, paid, change, dispense, sold_out
  );
endinterface

// File: rtl/vend_purchase_ctrl_stock_bank.sv
// Seven 3-bit stock registers with indexed decrement/refill and a flat view.
module vend_purchase_ctrl_stock_bank
  import vend_purchase_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic              dec,
  input  logic              restock,
  output logic [FLAT_W-1:0] stock_flat
);

  logic [STOCK_W-1:0] stock_q [NUM_GOODS];

  // Refill wins over decrement; an empty slot never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GOODS; i++) stock_q[i] <= STOCK_MAX;
    end else begin
      for (int i = 0; i < NUM_GOODS; i++) begin
        if (idx == IDX_W'(i)) begin
          if (restock)                          stock_q[i] <= STOCK_MAX;
          else if (dec && (stock_q[i] != '0))   stock_q[i] <= stock_q[i] - STOCK_W'(1);
        end
      end
    end
  end

  always_comb begin
    stock_flat = '0;
    for (int i = 0; i < NUM_GOODS; i++) stock_flat[i*STOCK_W +: STOCK_W] = stock_q[i];
  end

endmodule

// File: rtl/vend_purchase_ctrl.sv
// Purchase FSM: selection, coin accumulation, timeout refund, dispense and change hold.
module vend_purchase_ctrl
  import vend_purchase_ctrl_pkg::*;
#(
  parameter int unsigned PAY_TIMEOUT = 32'd500_000_000,
  parameter int unsigned CHANGE_HOLD = 32'd200_000_000
) (
  input  logic                 clk,
  input  logic                 EN,
  vend_purchase_ctrl_if.slave  bus
);

  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   behavior_q, behavior_d;
  logic [AMT_W-1:0]   paid_q,     paid_d;
  logic [AMT_W-1:0]   change_q,   change_d;
  logic               dispense_q, dispense_d;
  logic [CNT_W-1:0]   pay_cnt_q,  pay_cnt_d;
  logic [CNT_W-1:0]   chg_cnt_q,  chg_cnt_d;
  logic               dec_c;
  logic               restock_c;

  logic [FLAT_W-1:0]  goodleft;
  logic [STOCK_W-1:0] sel_stock;
  logic [AMT_W-1:0]   price;
  logic               coin_ok;
  logic [AMT_W-1:0]   coin_amt;
  logic [AMT_W-1:0]   paid_sum;
  logic               timeout;

  vend_purchase_ctrl_stock_bank u_stock_bank (
    .clk        (clk),
    .rst_n      (EN),
    .idx        (behavior_q),
    .dec        (dec_c),
    .restock    (restock_c),
    .stock_flat (goodleft)
  );

  always_comb begin
    sel_stock = '0;
    for (int i = 0; i < NUM_GOODS; i++) begin
      if (behavior_q == IDX_W'(i)) sel_stock = goodleft[i*STOCK_W +: STOCK_W];
    end
  end

  assign price    = price_of(behavior_q);
  assign coin_ok  = bus.coin_valid && coin_legal(bus.coin_val);
  assign coin_amt = coin_ok ? AMT_W'(bus.coin_val) : '0;
  assign paid_sum = paid_q + coin_amt;
  assign timeout  = (pay_cnt_q == CNT_W'(PAY_TIMEOUT - 1));

  always_ff @(posedge clk or negedge EN) begin
    if (!EN) begin
      state_q    <= ST_IDLE;
      behavior_q <= '0;
      paid_q     <= '0;
      change_q   <= '0;
      dispense_q <= 1'b0;
      pay_cnt_q  <= '0;
      chg_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      behavior_q <= behavior_d;
      paid_q     <= paid_d;
      change_q   <= change_d;
      dispense_q <= dispense_d;
      pay_cnt_q  <= pay_cnt_d;
      chg_cnt_q  <= chg_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    behavior_d = behavior_q;
    paid_d     = paid_q;
    change_d   = change_q;
    dispense_d = 1'b0;
    pay_cnt_d  = pay_cnt_q;
    chg_cnt_d  = chg_cnt_q;
    dec_c      = 1'b0;
    restock_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.sel_next) begin
          behavior_d = (behavior_q == IDX_W'(NUM_GOODS - 1)) ? '0 : behavior_q + IDX_W'(1);
        end
        restock_c = bus.restock;
        if (bus.confirm && (sel_stock != '0)) begin
          state_d   = ST_PAY;
          paid_d    = '0;
          change_d  = '0;
          pay_cnt_d = '0;
        end
      end
      ST_PAY: begin
        paid_d = paid_sum;
        // Cancel and timeout collapse into one refund that includes a same-cycle coin.
        if (bus.cancel || timeout) begin
          change_d  = paid_sum;
          chg_cnt_d = '0;
          state_d   = ST_CHANGE;
        end else begin
          pay_cnt_d = coin_ok ? '0 : pay_cnt_q + CNT_W'(1);
          if (paid_q >= price) begin
            state_d    = ST_DISPENSE;
            dispense_d = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        dec_c     = 1'b1;
        change_d  = paid_q - price;
        chg_cnt_d = '0;
        state_d   = ST_CHANGE;
      end
      ST_CHANGE: begin
        if (chg_cnt_q == CNT_W'(CHANGE_HOLD - 1)) begin
          state_d = ST_IDLE;
          paid_d  = '0;
        end else begin
          chg_cnt_d = chg_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.behavior = behavior_q;
  assign bus.goodleft = goodleft;
  assign bus.state    = 2'(state_q);
  assign bus.paid     = paid_q;
  assign bus.change   = change_q;
  assign bus.dispense = dispense_q;
  assign bus.sold_out = (sel_stock == '0);

endmodule

// File: tb/tb_vend_purchase_ctrl.sv
// Directed self-checking bench for vend_purchase_ctrl (PAY_TIMEOUT=20, CHANGE_HOLD=4).
module tb_vend_purchase_ctrl;

  logic clk;
  logic en;
  int   checks;
  int   errors;
  logic disp_seen;

  vend_purchase_ctrl_if bus ();

  vend_purchase_ctrl #(
    .PAY_TIMEOUT (20),
    .CHANGE_HOLD (4)
  ) dut (
    .clk (clk),
    .EN  (en),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel();
    bus.sel_next = 1'b1; step(); bus.sel_next = 1'b0;
  endtask

  task automatic confirm();
    bus.confirm = 1'b1; step(); bus.confirm = 1'b0;
  endtask

  task automatic restock_p();
    bus.restock = 1'b1; step(); bus.restock = 1'b0;
  endtask

  task automatic coin(input logic [2:0] v);
    bus.coin_valid = 1'b1; bus.coin_val = v; step();
    bus.coin_valid = 1'b0; bus.coin_val = 3'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    en = 1'b0;
    bus.sel_next = 1'b0; bus.confirm = 1'b0; bus.cancel = 1'b0;
    bus.coin_valid = 1'b0; bus.coin_val = 3'd0; bus.restock = 1'b0;
    step(); step();

    chk("rst_state",    32'(bus.state),    32'd0);
    chk("rst_behavior", 32'(bus.behavior), 32'd0);
    chk("rst_goodleft", 32'(bus.goodleft), 32'h1FFFFF);
    chk("rst_paid",     32'(bus.paid),     32'd0);
    chk("rst_change",   32'(bus.change),   32'd0);
    chk("rst_dispense", 32'(bus.dispense), 32'd0);
    chk("rst_sold_out", 32'(bus.sold_out), 32'd0);
    en = 1'b1;
    step();

    // Coins in IDLE are ignored
    coin(3'd2);
    chk("idle_coin_paid",  32'(bus.paid),  32'd0);
    chk("idle_coin_state", 32'(bus.state), 32'd0);

    // Good 4 (price 4), exact payment
    repeat (3) sel();
    chk("g4_behavior", 32'(bus.behavior), 32'd3);
    confirm();
    chk("g4_state_pay", 32'(bus.state), 32'd1);
    chk("g4_paid0",     32'(bus.paid),  32'd0);
    coin(3'd2);
    chk("g4_paid2", 32'(bus.paid), 32'd2);
    coin(3'd2);
    chk("g4_paid4",  32'(bus.paid),  32'd4);
    chk("g4_in_pay", 32'(bus.state), 32'd1);
    step();
    chk("g4_dispense_state", 32'(bus.state),    32'd2);
    chk("g4_dispense_pulse", 32'(bus.dispense), 32'd1);
    step();
    chk("g4_change_state", 32'(bus.state),         32'd3);
    chk("g4_dispense_off", 32'(bus.dispense),      32'd0);
    chk("g4_stock",        32'(bus.goodleft[11:9]), 32'd6);
    chk("g4_change",       32'(bus.change),        32'd0);
    repeat (3) step();
    chk("g4_still_change", 32'(bus.state), 32'd3);
    step();
    chk("g4_idle",       32'(bus.state), 32'd0);
    chk("g4_paid_clear", 32'(bus.paid),  32'd0);

    // Good 7 (price 7), overpay with 5+5
    repeat (3) sel();
    chk("g7_behavior", 32'(bus.behavior), 32'd6);
    confirm();
    coin(3'd5);
    coin(3'd5);
    chk("g7_paid10", 32'(bus.paid), 32'd10);
    step();
    chk("g7_dispense_state", 32'(bus.state), 32'd2);
    step();
    chk("g7_change", 32'(bus.change),          32'd3);
    chk("g7_stock",  32'(bus.goodleft[20:18]), 32'd6);
    repeat (4) step();
    chk("g7_idle",        32'(bus.state),  32'd0);
    chk("g7_change_kept", 32'(bus.change), 32'd3);

    // Wrap to good 1, empty it, confirm refused, restock
    sel();
    chk("wrap_to_0", 32'(bus.behavior), 32'd0);
    for (int k = 0; k < 7; k++) begin
      confirm();
      coin(3'd2);
      repeat (6) step();
    end
    chk("g1_empty",    32'(bus.goodleft[2:0]), 32'd0);
    chk("g1_sold_out", 32'(bus.sold_out),      32'd1);
    confirm();
    chk("g1_confirm_refused", 32'(bus.state), 32'd0);
    restock_p();
    chk("g1_restocked",    32'(bus.goodleft[2:0]), 32'd7);
    chk("g1_sold_out_off", 32'(bus.sold_out),      32'd0);

    // Cancel with a same-cycle coin
    confirm();
    coin(3'd1);
    chk("cxl_paid1", 32'(bus.paid), 32'd1);
    bus.cancel = 1'b1; bus.coin_valid = 1'b1; bus.coin_val = 3'd2;
    step();
    bus.cancel = 1'b0; bus.coin_valid = 1'b0; bus.coin_val = 3'd0;
    chk("cxl_state",    32'(bus.state),         32'd3);
    chk("cxl_change",   32'(bus.change),        32'd3);
    chk("cxl_dispense", 32'(bus.dispense),      32'd0);
    chk("cxl_stock",    32'(bus.goodleft[2:0]), 32'd7);
    disp_seen = 1'b0;
    repeat (4) begin
      step();
      if (bus.dispense) disp_seen = 1'b1;
    end
    chk("cxl_no_dispense", 32'(disp_seen),  32'd0);
    chk("cxl_idle",        32'(bus.state),  32'd0);
    chk("cxl_change_kept", 32'(bus.change), 32'd3);

    // Timeout with illegal coins and an ignored sel_next
    confirm();
    chk("to_pay", 32'(bus.state), 32'd1);
    for (int i = 0; i < 19; i++) begin
      if (i == 4 || i == 9) begin
        bus.coin_valid = 1'b1; bus.coin_val = 3'd3;
      end
      if (i == 12) bus.sel_next = 1'b1;
      step();
      bus.coin_valid = 1'b0; bus.coin_val = 3'd0; bus.sel_next = 1'b0;
    end
    chk("to_still_pay",   32'(bus.state),    32'd1);
    chk("to_paid0",       32'(bus.paid),     32'd0);
    chk("to_sel_ignored", 32'(bus.behavior), 32'd0);
    step();
    chk("to_change_state", 32'(bus.state),  32'd3);
    chk("to_change0",      32'(bus.change), 32'd0);
    coin(3'd2);
    chk("to_change_coin_ignored", 32'(bus.paid), 32'd0);
    repeat (3) step();
    chk("to_idle", 32'(bus.state), 32'd0);

    // Reset during PAY
    repeat (4) sel();
    chk("rp_behavior", 32'(bus.behavior), 32'd4);
    confirm();
    coin(3'd2);
    coin(3'd2);
    chk("rp_paid4", 32'(bus.paid),  32'd4);
    chk("rp_pay",   32'(bus.state), 32'd1);
    #2 en = 1'b0;
    #1;
    chk("rp_state",    32'(bus.state),    32'd0);
    chk("rp_paid",     32'(bus.paid),     32'd0);
    chk("rp_goodleft", 32'(bus.goodleft), 32'h1FFFFF);
    chk("rp_behavior0",32'(bus.behavior), 32'd0);
    chk("rp_dispense", 32'(bus.dispense), 32'd0);
    chk("rp_change",   32'(bus.change),   32'd0);
    step();
    en = 1'b1;
    step();
    repeat (6) sel();
    chk("rp_sel6", 32'(bus.behavior), 32'd6);
    sel();
    chk("rp_wrap", 32'(bus.behavior), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
